// File: rtl/hyper_uart_bridge_if.sv
// Signal bundle joining the command bridge to the UART rx/tx pair and the HyperRAM controller.
// The master side is the bridge; the slave side is the UART and controller environment.
interface hyper_uart_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic                  rd_req;
  logic                  wr_req;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wr_d;
  logic [DATA_W/8-1:0]   wr_byte_en;
  logic [5:0]            rd_num_dwords;
  logic [DATA_W-1:0]     rd_d;
  logic                  rd_rdy;
  logic                  busy;
  logic [7:0]            err_cnt;

  modport master (
    input  rx_valid, rx_data, tx_ready, rd_d, rd_rdy, busy,
    output tx_start, tx_data, rd_req, wr_req, addr, wr_d, wr_byte_en, rd_num_dwords, err_cnt
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, rd_d, rd_rdy, busy,
    input  tx_start, tx_data, rd_req, wr_req, addr, wr_d, wr_byte_en, rd_num_dwords, err_cnt
  );
endinterface

// File: rtl/hyper_uart_bridge.sv
// Byte-serial command bridge: assembles UART frames, runs buffered HyperRAM bursts,
// and answers every accepted command with exactly DATA_W/8 response bytes.
module hyper_uart_bridge #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MAX_BURST  = 8,
  parameter int ADDR_STEP  = 2,
  parameter int RX_TIMEOUT = 1000000,
  parameter int CONST_VAL  = 259
) (
  input logic clk,
  input logic reset,
  hyper_uart_bridge_if.master bus
);
  localparam int NB  = DATA_W / 8;
  localparam int FCW = $clog2(NB + 1);
  localparam int PW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam int TW  = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, EXEC, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, RESP_RDY, RESP_ACK
  } state_e;

  state_e state_q, state_d;

  logic [FCW-1:0]      frame_cnt_q, frame_cnt_d;
  logic [TW-1:0]       idle_cnt_q, idle_cnt_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   pay_q, pay_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wr_d_q, wr_d_d;
  logic [NB-1:0]       byte_en_q, byte_en_d;
  logic [5:0]          rd_num_q, rd_num_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                wr_req_q, wr_req_d;
  logic                rd_req_q, rd_req_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0]   resp_q, resp_d;
  logic [FCW-1:0]      sent_q, sent_d;
  logic [1:0]          guard_q, guard_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]       written_q, written_d;
  logic                seen_busy_q, seen_busy_d;
  logic [5:0]          rd_got_q, rd_got_d;
  logic [PW-1:0]       wwr_ptr_q, wwr_ptr_d, wrd_ptr_q, wrd_ptr_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic [PW-1:0]       rwr_ptr_q, rwr_ptr_d, rrd_ptr_q, rrd_ptr_d;
  logic [CW-1:0]       rcnt_q, rcnt_d;

  logic [DATA_W-1:0]   wbuf [MAX_BURST];
  logic [DATA_W-1:0]   rbuf [MAX_BURST];

  logic wpush, wpop, rpush, rpop, rclear, unknown;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  logic frame_done, drop, timeout, tx_acc, last_byte, wr_done, rd_push, rd_last, rreq_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_BURST - 1)) ? '0 : p + PW'(1);
  endfunction

  assign frame_done = bus.rx_valid && (frame_cnt_q == FCW'(NB));
  assign drop       = frame_done && (state_q != IDLE);
  assign timeout    = !bus.rx_valid && (frame_cnt_q != '0) && (idle_cnt_q == TW'(RX_TIMEOUT - 1));
  // A byte counts as taken when tx_ready drops, or after four cycles if it never does.
  assign tx_acc     = (state_q == RESP_ACK) && (!bus.tx_ready || guard_q == 2'd3);
  assign last_byte  = (sent_q == FCW'(NB - 1));
  assign wr_done    = (state_q == WR_WAIT) && seen_busy_q && !bus.busy;
  assign rd_push    = (state_q == RD_WAIT) && bus.rd_rdy;
  assign rd_last    = rd_push && ((rd_got_q + 6'd1) == rd_num_q);
  assign rreq_ok    = (pay_q != '0) && (pay_q <= DATA_W'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (frame_done) state_d = EXEC;
      EXEC: begin
        state_d = RESP_RDY;
        if (cmd_q == 8'h03 && wcnt_q != '0) state_d = WR_ISSUE;
        if (cmd_q == 8'h05 && rreq_ok)      state_d = RD_ISSUE;
      end
      WR_ISSUE: if (!bus.busy) state_d = WR_WAIT;
      WR_WAIT:  if (wr_done) state_d = (wcnt_q == CW'(1)) ? RESP_RDY : WR_ISSUE;
      RD_ISSUE: if (!bus.busy) state_d = RD_WAIT;
      RD_WAIT:  if (rd_last) state_d = RESP_RDY;
      RESP_RDY: if (bus.tx_ready) state_d = RESP_ACK;
      RESP_ACK: if (tx_acc) state_d = last_byte ? IDLE : RESP_RDY;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;  idle_cnt_d = idle_cnt_q;  cmd_d = cmd_q;  pay_d = pay_q;
    addr_d = addr_q;  wr_d_d = wr_d_q;  byte_en_d = byte_en_q;  rd_num_d = rd_num_q;
    tx_data_d = tx_data_q;  tx_start_d = 1'b0;  wr_req_d = 1'b0;  rd_req_d = 1'b0;
    resp_d = resp_q;  sent_d = sent_q;  guard_d = guard_q;  cnt_d = cnt_q;
    written_d = written_q;  seen_busy_d = seen_busy_q;  rd_got_d = rd_got_q;
    wwr_ptr_d = wwr_ptr_q;  wrd_ptr_d = wrd_ptr_q;  wcnt_d = wcnt_q;
    rwr_ptr_d = rwr_ptr_q;  rrd_ptr_d = rrd_ptr_q;  rcnt_d = rcnt_q;
    wpush = 1'b0;  wpop = 1'b0;  rpush = 1'b0;  rpop = 1'b0;  rclear = 1'b0;  unknown = 1'b0;

    // Frame assembly runs in every state so busy-time frames can be counted and dropped.
    if (bus.rx_valid) begin
      idle_cnt_d = '0;
      if (frame_cnt_q == '0) begin
        cmd_d       = bus.rx_data;
        frame_cnt_d = FCW'(1);
      end else begin
        pay_d       = (pay_q << 8) | DATA_W'(bus.rx_data);
        frame_cnt_d = frame_done ? '0 : frame_cnt_q + FCW'(1);
      end
    end else if (timeout) begin
      frame_cnt_d = '0;
      idle_cnt_d  = '0;
    end else if (frame_cnt_q != '0) begin
      idle_cnt_d = idle_cnt_q + TW'(1);
    end

    case (state_q)
      EXEC: begin
        sent_d = '0;
        case (cmd_q)
          8'h01: begin addr_d = ADDR_W'(pay_q); resp_d = pay_q; end
          8'h02: begin
            if (wcnt_q == CW'(MAX_BURST)) resp_d = DATA_W'(32'hEEEEEE01);
            else begin wpush = 1'b1; resp_d = DATA_W'(wcnt_q) + DATA_W'(1); end
          end
          8'h03: begin
            if (wcnt_q == '0) resp_d = DATA_W'(32'hEEEEEE02);
            else written_d = '0;
          end
          8'h04: begin
            if (rcnt_q == '0) resp_d = DATA_W'(32'hEEEEEE03);
            else begin rpop = 1'b1; resp_d = rbuf[rrd_ptr_q]; end
          end
          8'h05: begin
            if (rreq_ok) begin rclear = 1'b1; rd_num_d = pay_q[5:0]; end
            else resp_d = DATA_W'(32'hEEEEEE04);
          end
          8'h06: begin resp_d = cnt_q; cnt_d = cnt_q + DATA_W'(1); end
          8'h07: resp_d = DATA_W'(CONST_VAL);
          8'h08: begin byte_en_d = pay_q[NB-1:0]; resp_d = pay_q; end
          default: begin resp_d = DATA_W'(32'hEEEEEEFF); unknown = 1'b1; end
        endcase
      end
      WR_ISSUE: if (!bus.busy) begin
        wr_req_d    = 1'b1;
        wr_d_d      = wbuf[wrd_ptr_q];
        seen_busy_d = 1'b0;
      end
      WR_WAIT: begin
        if (bus.busy) seen_busy_d = 1'b1;
        if (wr_done) begin
          wpop      = 1'b1;
          addr_d    = addr_q + ADDR_W'(ADDR_STEP);
          written_d = written_q + CW'(1);
          resp_d    = DATA_W'(written_q) + DATA_W'(1);
        end
      end
      RD_ISSUE: if (!bus.busy) begin rd_req_d = 1'b1; rd_got_d = '0; end
      RD_WAIT: if (rd_push) begin
        rpush    = 1'b1;
        rd_got_d = rd_got_q + 6'd1;
        if (rd_last) resp_d = DATA_W'(rd_num_q);
      end
      RESP_RDY: if (bus.tx_ready) begin
        tx_start_d = 1'b1;
        tx_data_d  = resp_q[DATA_W-1 -: 8];
        guard_d    = '0;
      end
      RESP_ACK: begin
        if (tx_acc) begin
          resp_d = resp_q << 8;
          sent_d = sent_q + FCW'(1);
        end else begin
          guard_d = guard_q + 2'd1;
        end
      end
      default: ;
    endcase

    if (wpush) begin wwr_ptr_d = ptr_inc(wwr_ptr_q); wcnt_d = wcnt_q + CW'(1); end
    if (wpop)  begin wrd_ptr_d = ptr_inc(wrd_ptr_q); wcnt_d = wcnt_q - CW'(1); end
    if (rclear) begin rwr_ptr_d = '0; rrd_ptr_d = '0; rcnt_d = '0; end
    if (rpush) begin rwr_ptr_d = ptr_inc(rwr_ptr_q); rcnt_d = rcnt_q + CW'(1); end
    if (rpop)  begin rrd_ptr_d = ptr_inc(rrd_ptr_q); rcnt_d = rcnt_q - CW'(1); end

    err_inc   = 2'(drop) + 2'(timeout) + 2'(unknown);
    err_sum   = {1'b0, err_cnt_q} + 9'(err_inc);
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;  idle_cnt_q <= '0;  cmd_q <= '0;  pay_q <= '0;
      addr_q <= '0;  wr_d_q <= '0;  byte_en_q <= '1;  rd_num_q <= 6'd1;
      tx_data_q <= '0;  tx_start_q <= 1'b0;  wr_req_q <= 1'b0;  rd_req_q <= 1'b0;
      err_cnt_q <= '0;  resp_q <= '0;  sent_q <= '0;  guard_q <= '0;  cnt_q <= '0;
      written_q <= '0;  seen_busy_q <= 1'b0;  rd_got_q <= '0;
      wwr_ptr_q <= '0;  wrd_ptr_q <= '0;  wcnt_q <= '0;
      rwr_ptr_q <= '0;  rrd_ptr_q <= '0;  rcnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;  idle_cnt_q <= idle_cnt_d;  cmd_q <= cmd_d;  pay_q <= pay_d;
      addr_q <= addr_d;  wr_d_q <= wr_d_d;  byte_en_q <= byte_en_d;  rd_num_q <= rd_num_d;
      tx_data_q <= tx_data_d;  tx_start_q <= tx_start_d;  wr_req_q <= wr_req_d;  rd_req_q <= rd_req_d;
      err_cnt_q <= err_cnt_d;  resp_q <= resp_d;  sent_q <= sent_d;  guard_q <= guard_d;  cnt_q <= cnt_d;
      written_q <= written_d;  seen_busy_q <= seen_busy_d;  rd_got_q <= rd_got_d;
      wwr_ptr_q <= wwr_ptr_d;  wrd_ptr_q <= wrd_ptr_d;  wcnt_q <= wcnt_d;
      rwr_ptr_q <= rwr_ptr_d;  rrd_ptr_q <= rrd_ptr_d;  rcnt_q <= rcnt_d;
    end
  end

  // Buffer storage needs no reset; the pointers and fill counts define validity.
  always_ff @(posedge clk) begin
    if (wpush) wbuf[wwr_ptr_q] <= pay_q;
    if (rpush) rbuf[rwr_ptr_q] <= bus.rd_d;
  end

  assign bus.tx_start      = tx_start_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.rd_req        = rd_req_q;
  assign bus.wr_req        = wr_req_q;
  assign bus.addr          = addr_q;
  assign bus.wr_d          = wr_d_q;
  assign bus.wr_byte_en    = byte_en_q;
  assign bus.rd_num_dwords = rd_num_q;
  assign bus.err_cnt       = err_cnt_q;
endmodule

// File: doc/hyper_uart_bridge.md
Name: hyper_uart_bridge

Overview:
- Byte-serial command bridge between the UART rx/tx pair and the hyper_xface HyperRAM controller, clocked in the hram_clk domain.
- Successor to the fixed single-dword serial command logic. Adds:
  - parametrised data/address width;
  - burst writes and reads of up to MAX_BURST dwords, with on-chip buffers;
  - a programmable byte enable;
  - an inter-byte frame timeout;
  - an exact 4-byte response per command, with error codes.

Parameters:
- DATA_W, 32, data word width; multiple of 8, payload is DATA_W/8 bytes.
- ADDR_W, 32, HyperRAM address width.
- MAX_BURST, 8, depth of the write and read buffers (power of 2, ≤32).
- ADDR_STEP, 2, address increment per dword within a write burst.
- RX_TIMEOUT, 1000000, idle clocks after which a partial frame is discarded.
- CONST_VAL, 259, value returned by the CONST command.

Ports:
- clk  in  1  system clock (hram_clk).
- reset  in  1  synchronous, active-high.
- rx_valid  in  1  one-cycle strobe, rx_data valid (uart_rx rcv).
- rx_data  in  8  received byte.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_data  out  8  byte to transmit.
- tx_ready  in  1  uart_tx idle.
- rd_req  out  1  read request pulse.
- wr_req  out  1  write request pulse.
- addr  out  ADDR_W  request address.
- wr_d  out  DATA_W  write data.
- wr_byte_en  out  DATA_W/8  byte enables.
- rd_num_dwords  out  6  read burst length.
- rd_d  in  DATA_W  read data.
- rd_rdy  in  1  one-cycle strobe per read dword.
- busy  in  1  controller busy.
- err_cnt  out  8  saturating count of dropped frames and errors.

Behaviour:
- **Reset values:**
  - tx_start, rd_req, wr_req = 0; tx_data = 0; addr = 0; wr_d = 0.
  - wr_byte_en = all ones; rd_num_dwords = 1; err_cnt = 0.
  - Buffers empty, frame counter 0, state IDLE.
  - Reset mid-operation aborts everything. Any following rd_rdy pulses are ignored until the next READ_REQ.
- **Frame format:**
  - 1 command byte, then DATA_W/8 payload bytes, MSB first.
  - The frame is complete on the last rx_valid.
  - The idle counter restarts on every rx_valid. If it reaches RX_TIMEOUT with a partial frame, the frame counter clears and err_cnt increments.
- **Busy-time frames:** a frame completing while state ≠ IDLE is dropped and err_cnt increments. No response is sent.
- **Commands** (executed in the cycle after completion; P = payload):
  - 0x01 ADDR: addr ← P[ADDR_W-1:0]; respond P.
  - 0x02 LOAD: push P into the write buffer; respond the new fill level. If full: no push, respond 0xEEEEEE01.
  - 0x03 WRITE:
    - Write buffer empty: respond 0xEEEEEE02.
    - Otherwise go to WR_ISSUE. Per entry: wait busy=0, then pulse wr_req for 1 cycle with wr_d = head entry. Next go to WR_WAIT: wait for busy to rise then fall, pop the entry, addr += ADDR_STEP (wraps modulo 2^ADDR_WIDTH).
    - Respond with the dword count written. The buffer is empty afterwards.
  - 0x04 READ:
    - Pop the read buffer; respond with the popped word.
    - If empty: respond 0xEEEEEE03.
  - 0x05 READ_REQ:
    - Valid only if P is in 1..MAX_BURST; otherwise respond 0xEEEEEE04.
    - Clear the read buffer, set rd_num_dwords = P, wait busy=0, pulse rd_req for 1 cycle, then enter RD_WAIT.
    - In RD_WAIT, each rd_rdy pushes rd_d. Exit after P pushes, then respond P.
    - Extra rd_rdy pulses are ignored.
  - 0x06 COUNT: respond the internal counter, then increment it (wraps).
  - 0x07 CONST: respond CONST_VAL.
  - 0x08 BYTE_EN: wr_byte_en ← P[DATA_W/8-1:0]; respond P.
  - Other opcodes: respond 0xEEEEEEFF and increment err_cnt.
  - Responses of width DATA_W zero-extend the 32-bit constants.
- **RESP state:**
  - Sends exactly DATA_W/8 bytes, MSB first.
  - Per byte: wait tx_ready=1, pulse tx_start for 1 cycle with tx_data held, wait for tx_ready=0, then go to the next byte.
  - Return to IDLE after the last byte.
- **No-ready guard:** if tx_ready stays 1 for 4 cycles after tx_start, treat the byte as accepted.
- **Buffer limits:** buffers are FIFOs of depth MAX_BURST; full and empty are exact (no off-by-one). Simultaneous push and pop never occurs.
- err_cnt saturates at 255.

Test Plan:
- ADDR 0x00000100, LOAD 0xDEADBEEF, LOAD 0x12345678, WRITE:
  - two wr_req pulses, with addr 0x100 then 0x102 and wr_d in the same order;
  - responses 0x00000100, 1, 2, 2 (4 bytes each).
- READ_REQ 3, with the model asserting rd_rdy three times (0xA, 0xB, 0xC):
  - rd_num_dwords = 3 and one rd_req pulse;
  - response 3;
  - three READs return 0xA, 0xB, 0xC; a fourth READ returns 0xEEEEEE03.
- Error cases:
  - MAX_BURST+1 LOADs: the last returns 0xEEEEEE01.
  - READ_REQ 0 returns 0xEEEEEE04.
  - opcode 0x55 returns 0xEEEEEEFF.
  - err_cnt = 1 after these, because only the unknown-opcode case increments err_cnt.
- Send 3 bytes, idle RX_TIMEOUT cycles, then a full CONST frame: response 0x00000103 and err_cnt = 1.
- Frame completed during a WRITE burst with busy held high: no response, err_cnt increments, and the burst completes normally.
- Reset asserted in RD_WAIT after 1 of 3 rd_rdy pulses: all outputs return to reset values, and a subsequent READ returns 0xEEEEEE03.
